// File: rtl/demux_sel_sequencer.sv
// Sequencer for a 1-to-8 demux: it walks select S across the enabled channels and drives data bit D on each.
// Optional macro DEMUX_SEQ_CNT_EN adds a 16-bit count of completed frames.
module demux_sel_sequencer #(
   parameter int unsigned HOLD_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic [7:0]  in_mask,
   output logic        D,
   output logic [2:0]  S,
   output logic        d_strobe,
   output logic        busy,
`ifdef DEMUX_SEQ_CNT_EN
   output logic        done,
   output logic [15:0] frame_cnt
`else
   output logic        done
`endif
);

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
      $error("demux_sel_sequencer: HOLD_CYCLES must be within 1..255");
   end

   localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

   state_t      state, state_n;
   logic [7:0]  data_q, data_n;
   logic [7:0]  rem_q, rem_n;     // enabled channels not yet driven
   logic [7:0]  cnt_q, cnt_n;
   logic [2:0]  s_n;
   logic        d_n, strobe_n, busy_n, done_n, ready_n;

   function automatic logic [2:0] lowest_idx(input logic [7:0] m);
      lowest_idx = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (m[i]) lowest_idx = i[2:0];
   endfunction

   // NOTE: every output of this block is assigned a default before the case statement, so no latch is inferred.
   always_comb begin
      state_n  = state;
      data_n   = data_q;
      rem_n    = rem_q;
      cnt_n    = cnt_q;
      s_n      = 3'd0;
      d_n      = 1'b0;
      strobe_n = 1'b0;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      ready_n  = 1'b0;
      case (state)
         IDLE: begin
            ready_n = 1'b1;
            if (in_valid && in_ready) begin
               data_n  = in_data;
               busy_n  = 1'b1;
               ready_n = 1'b0;
               if (in_mask != 8'd0) begin
                  state_n  = DRIVE;
                  s_n      = lowest_idx(in_mask);
                  d_n      = in_data[s_n];
                  strobe_n = 1'b1;
                  rem_n    = in_mask & (in_mask - 8'd1);
                  cnt_n    = HOLD_RELOAD;
               end else begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end
            end
         end
         DRIVE: begin
            busy_n = 1'b1;
            if (cnt_q != 8'd0) begin
               cnt_n    = cnt_q - 8'd1;
               s_n      = S;
               d_n      = D;
               strobe_n = 1'b1;
            end else if (rem_q != 8'd0) begin
               s_n      = lowest_idx(rem_q);
               d_n      = data_q[s_n];
               strobe_n = 1'b1;
               rem_n    = rem_q & (rem_q - 8'd1);
               cnt_n    = HOLD_RELOAD;
            end else begin
               state_n = DONE;
               done_n  = 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
            ready_n = 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         data_q   <= 8'd0;
         rem_q    <= 8'd0;
         cnt_q    <= 8'd0;
         S        <= 3'd0;
         D        <= 1'b0;
         d_strobe <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         in_ready <= 1'b0;
      end else begin
         state    <= state_n;
         data_q   <= data_n;
         rem_q    <= rem_n;
         cnt_q    <= cnt_n;
         S        <= s_n;
         D        <= d_n;
         d_strobe <= strobe_n;
         busy     <= busy_n;
         done     <= done_n;
         in_ready <= ready_n;
      end
   end

`ifdef DEMUX_SEQ_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         frame_cnt <= 16'd0;
      else if (done)
         frame_cnt <= frame_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Bench for demux_sel_sequencer: drives one instance with HOLD_CYCLES=1 and one with HOLD_CYCLES=3.
// A per-cycle expectation list is built straight from the channel mask and compared against both instances.
module tb_demux_sel_sequencer;

   logic        clk;
   logic        rst_n;
   logic        in_valid [2];
   logic        in_ready [2];
   logic [7:0]  in_data;
   logic [7:0]  in_mask;
   logic        d_o      [2];
   logic [2:0]  s_o      [2];
   logic        strobe   [2];
   logic        busy     [2];
   logic        done     [2];
`ifdef DEMUX_SEQ_CNT_EN
   logic [15:0] frame_cnt [2];
`endif

   int tests = 0;
   int fails = 0;

   logic [2:0] exp_s [$];
   logic       exp_d [$];

   demux_sel_sequencer #(.HOLD_CYCLES(1)) u_h1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data), .in_mask(in_mask), .D(d_o[0]), .S(s_o[0]),
      .d_strobe(strobe[0]), .busy(busy[0]),
`ifdef DEMUX_SEQ_CNT_EN
      .done(done[0]), .frame_cnt(frame_cnt[0])
`else
      .done(done[0])
`endif
   );

   demux_sel_sequencer #(.HOLD_CYCLES(3)) u_h3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data), .in_mask(in_mask), .D(d_o[1]), .S(s_o[1]),
      .d_strobe(strobe[1]), .busy(busy[1]),
`ifdef DEMUX_SEQ_CNT_EN
      .done(done[1]), .frame_cnt(frame_cnt[1])
`else
      .done(done[1])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Packed view {strobe, S, D, busy, done, in_ready}.
   function automatic logic [7:0] obs(input int k);
      return {strobe[k], s_o[k], d_o[k], busy[k], done[k], in_ready[k]};
   endfunction

   function automatic logic [7:0] pack(input logic st, input logic [2:0] s, input logic d,
                                       input logic b, input logic dn, input logic r);
      return {st, s, d, b, dn, r};
   endfunction

   // Expected strobe cycles: every enabled channel in ascending order, HOLD times each.
   task automatic build_model(input logic [7:0] data, input logic [7:0] mask, input int hold);
      exp_s.delete();
      exp_d.delete();
      for (int ch = 0; ch < 8; ch++)
         if (mask[ch])
            for (int h = 0; h < hold; h++) begin
               exp_s.push_back(3'(ch));
               exp_d.push_back(data[ch]);
            end
   endtask

   task automatic test_frame(input int k, input logic [7:0] data, input logic [7:0] mask);
      int budget;
      logic [7:0] want;
`ifdef DEMUX_SEQ_CNT_EN
      logic [15:0] cnt_before;
`endif
      @(negedge clk);
      budget = 0;
      while (!in_ready[k] && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      tests++;
      if (!in_ready[k]) begin
         fails++;
         $display("FAIL accept_wait inst=%0d: in_ready never rose", k);
         return;
      end
`ifdef DEMUX_SEQ_CNT_EN
      cnt_before = frame_cnt[k];
`endif
      build_model(data, mask, (k == 0) ? 1 : 3);
      in_data     = data;
      in_mask     = mask;
      in_valid[k] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[k] = 1'b0;
      in_data     = 8'($urandom);
      in_mask     = 8'($urandom);
      foreach (exp_s[i]) begin
         @(negedge clk);
         want = pack(1'b1, exp_s[i], exp_d[i], 1'b1, 1'b0, 1'b0);
         tests++;
         if (obs(k) !== want) begin
            fails++;
            $display("FAIL strobe_cycle inst=%0d data=%h mask=%h cyc=%0d got=%b exp=%b",
                     k, data, mask, i, obs(k), want);
         end
      end
      @(negedge clk);
      want = pack(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      tests++;
      if (obs(k) !== want) begin
         fails++;
         $display("FAIL done_cycle inst=%0d mask=%h got=%b exp=%b", k, mask, obs(k), want);
      end
      @(negedge clk);
      want = pack(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tests++;
      if (obs(k) !== want) begin
         fails++;
         $display("FAIL idle_after inst=%0d mask=%h got=%b exp=%b", k, mask, obs(k), want);
      end
`ifdef DEMUX_SEQ_CNT_EN
      tests++;
      if (frame_cnt[k] !== 16'(cnt_before + 16'd1)) begin
         fails++;
         $display("FAIL frame_cnt inst=%0d got=%h exp=%h", k, frame_cnt[k], 16'(cnt_before + 16'd1));
      end
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            tests++;
            if (obs(k) !== 8'd0) begin
               fails++;
               $display("FAIL reset_hold inst=%0d got=%b exp=%b", k, obs(k), 8'd0);
            end
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         tests++;
         if (obs(k) !== pack(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1)) begin
            fails++;
            $display("FAIL reset_release inst=%0d got=%b exp=%b", k, obs(k),
                     pack(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int budget;
      @(negedge clk);
      in_data     = 8'($urandom);
      in_mask     = 8'hFF;
      in_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      budget = 0;
      do begin
         @(negedge clk);
         budget++;
      end while (s_o[0] !== 3'd4 && budget < 20);
      tests++;
      if (s_o[0] !== 3'd4) begin
         fails++;
         $display("FAIL mid_frame_reach got S=%0d exp S=4", s_o[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (obs(0) !== 8'd0) begin
         fails++;
         $display("FAIL async_reset got=%b exp=%b", obs(0), 8'd0);
      end
      repeat (2) begin
         @(negedge clk);
         tests++;
         if (done[0] !== 1'b0 || strobe[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_done got done=%b strobe=%b exp 0 0", done[0], strobe[0]);
         end
      end
      rst_n = 1'b1;
      test_frame(0, 8'($urandom), 8'hFF);
   endtask

   task automatic test_back_to_back();
      logic [7:0] d1, d2;
      logic [7:0] want [8];
      int budget;
      d1 = 8'($urandom);
      d2 = 8'($urandom);
      want[0] = pack(1'b1, 3'd0, d1[0], 1'b1, 1'b0, 1'b0);
      want[1] = pack(1'b1, 3'd1, d1[1], 1'b1, 1'b0, 1'b0);
      want[2] = pack(1'b0, 3'd0, 1'b0,  1'b1, 1'b1, 1'b0);
      want[3] = pack(1'b0, 3'd0, 1'b0,  1'b0, 1'b0, 1'b1);
      want[4] = pack(1'b1, 3'd2, d2[2], 1'b1, 1'b0, 1'b0);
      want[5] = pack(1'b1, 3'd3, d2[3], 1'b1, 1'b0, 1'b0);
      want[6] = pack(1'b0, 3'd0, 1'b0,  1'b1, 1'b1, 1'b0);
      want[7] = pack(1'b0, 3'd0, 1'b0,  1'b0, 1'b0, 1'b1);
      @(negedge clk);
      budget = 0;
      while (!in_ready[0] && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      in_data     = d1;
      in_mask     = 8'h03;
      in_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      in_data = d2;
      in_mask = 8'h0C;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         tests++;
         if (obs(0) !== want[i]) begin
            fails++;
            $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i, obs(0), want[i]);
         end
         if (i == 3) begin
            @(posedge clk);
            #1 in_valid[0] = 1'b0;
         end
      end
   endtask

`ifdef DEMUX_SEQ_CNT_EN
   task automatic test_cnt_wrap();
      @(negedge clk);
      force u_h1.frame_cnt = 16'hFFFF;
      #1;
      release u_h1.frame_cnt;
      test_frame(0, 8'h00, 8'h00);
      tests++;
      if (frame_cnt[0] !== 16'h0000) begin
         fails++;
         $display("FAIL cnt_wrap got=%h exp=%h", frame_cnt[0], 16'h0000);
      end
   endtask
`endif

   task automatic test_random();
      logic [7:0] m;
      repeat (30) begin
         m = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         test_frame(int'($urandom_range(0, 1)), 8'($urandom), m);
      end
   endtask

   initial begin
      in_valid[0] = 1'b0;
      in_valid[1] = 1'b0;
      in_data     = 8'h00;
      in_mask     = 8'h00;
      test_reset();
      test_frame(0, 8'hA5, 8'hFF);
      test_frame(1, 8'h81, 8'h81);
      test_frame(0, 8'h5A, 8'h00);
      test_frame(1, 8'hFF, 8'h00);
      test_reset_mid_frame();
      test_back_to_back();
`ifdef DEMUX_SEQ_CNT_EN
      test_cnt_wrap();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
